shift_pipe: RTL and testbench



---
 rtl/shift_pipe_pkg.sv | 31 +++
 rtl/shift_norm.sv | 106 ++++++++++
 rtl/shift_pipe.sv | 138 +++++++++++++
 tb/tb_shift_pipe.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared types for the pipelined barrel shifter: op codes, per-stage control bits,
// and the helper used to split the mux layers across register stages.
package shift_pipe_pkg;

    typedef enum logic [2:0] {
        SH_LSL = 3'd0,
        SH_LSR = 3'd1,
        SH_ASR = 3'd2,
        SH_ROR = 3'd3,
        SH_RRX = 3'd4
    } sh_op_e;

    // Control carried alongside the data through every stage. Right shifts pull
    // fill into the vacated top bits; the force flags override the final result.
    typedef struct packed {
        sh_op_e op;
        logic   fill;
        logic   force_zero;
        logic   force_sign;
    } sh_ctrl_t;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_norm.sv
// Stage-0 normalisation: resolves the effective amount, selects the carry-out and
// reduces every case to a plain mux-layer shift plus fill/force control.
module shift_norm
    import shift_pipe_pkg::*;
#(
    parameter int W     = 32,
    parameter int AMT_W = 8
) (
    input  logic [W-1:0]          data,
    input  logic [AMT_W-1:0]      amt,
    input  logic [1:0]            op,
    input  logic                  reg_form,
    input  logic                  c_flag,
    output logic [W-1:0]          norm_data,
    output logic                  norm_c,
    output logic [clog2(W)-1:0]   norm_amt,
    output sh_ctrl_t              norm_ctrl
);

    localparam int LOG_W = clog2(W);

    sh_op_e           op_e;
    logic [31:0]      n;
    logic             imm_zero;
    logic             is_rrx;
    logic             lt_w;
    logic             eq_w;
    logic [LOG_W-1:0] idx_up;
    logic [LOG_W-1:0] idx_dn;

    always_comb begin
        op_e     = sh_op_e'({1'b0, op});
        imm_zero = (amt[4:0] == 5'd0);
        is_rrx   = !reg_form && imm_zero && (op_e == SH_ROR);

        // Immediate #0 on LSR/ASR encodes a shift by the full width.
        if (reg_form) begin
            n = 32'(amt);
        end else if (imm_zero && (op_e == SH_LSR || op_e == SH_ASR)) begin
            n = 32'(W);
        end else begin
            n = 32'(amt[4:0]);
        end

        lt_w   = (n < 32'(W));
        eq_w   = (n == 32'(W));
        idx_up = LOG_W'(32'(W) - n);
        idx_dn = LOG_W'(n - 32'd1);
    end

    always_comb begin
        norm_data            = data;
        norm_c               = c_flag;
        norm_amt             = '0;
        norm_ctrl.op         = op_e;
        norm_ctrl.fill       = 1'b0;
        norm_ctrl.force_zero = 1'b0;
        norm_ctrl.force_sign = 1'b0;

        if (is_rrx) begin
            // RRX is a one-bit right shift that pulls the old C flag into the MSB.
            norm_ctrl.op   = SH_RRX;
            norm_ctrl.fill = c_flag;
            norm_amt       = LOG_W'(1);
            norm_c         = data[0];
        end else if (n != 32'd0) begin
            unique case (op_e)
                SH_LSL: begin
                    if (lt_w) begin
                        norm_amt = n[LOG_W-1:0];
                        norm_c   = data[idx_up];
                    end else begin
                        norm_ctrl.force_zero = 1'b1;
                        norm_c               = eq_w ? data[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (lt_w) begin
                        norm_amt = n[LOG_W-1:0];
                        norm_c   = data[idx_dn];
                    end else begin
                        norm_ctrl.force_zero = 1'b1;
                        norm_c               = eq_w ? data[W-1] : 1'b0;
                    end
                end
                SH_ASR: begin
                    norm_ctrl.fill = data[W-1];
                    if (lt_w) begin
                        norm_amt = n[LOG_W-1:0];
                        norm_c   = data[idx_dn];
                    end else begin
                        norm_ctrl.force_sign = 1'b1;
                        norm_c               = data[W-1];
                    end
                end
                SH_ROR: begin
                    // Rotation wraps, so only the low bits of the amount matter.
                    norm_amt = n[LOG_W-1:0];
                    norm_c   = (n[LOG_W-1:0] == '0) ? data[W-1] : data[idx_dn];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined ARM-style operand shifter: stage-0 normalisation, then log2(W) mux layers
// split evenly across PIPE register stages with a valid/ready stall chain.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int W     = 32,
    parameter int AMT_W = 8,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    input  logic             in_reg_form,
    input  logic             in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_c
);

    localparam int LOG_W = clog2(W);

    typedef struct packed {
        logic [W-1:0]     data;
        logic             c;
        logic [LOG_W-1:0] amt;
        sh_ctrl_t         ctrl;
    } payload_t;

    logic [W-1:0]     norm_data;
    logic             norm_c;
    logic [LOG_W-1:0] norm_amt;
    sh_ctrl_t         norm_ctrl;

    payload_t         stage_in [PIPE];
    payload_t         pay_nx   [PIPE];
    payload_t         pay_q    [PIPE];
    logic [PIPE-1:0]  valid_q;
    logic [PIPE-1:0]  vld_in;
    logic [PIPE-1:0]  can_load;

    shift_norm #(
        .W     (W),
        .AMT_W (AMT_W)
    ) u_norm (
        .data      (in_data),
        .amt       (in_amt),
        .op        (in_op),
        .reg_form  (in_reg_form),
        .c_flag    (in_c),
        .norm_data (norm_data),
        .norm_c    (norm_c),
        .norm_amt  (norm_amt),
        .norm_ctrl (norm_ctrl)
    );

    function automatic logic [W-1:0] layer(input logic [W-1:0] d, input sh_op_e op,
                                           input logic fill, input int step);
        logic [W-1:0] ones;
        logic [W-1:0] r;
        ones = '1;
        case (op)
            SH_LSL:  r = d << step;
            SH_ROR:  r = (d >> step) | (d << (W - step));
            default: r = (d >> step) | (fill ? ~(ones >> step) : '0);
        endcase
        return r;
    endfunction

    always_comb begin
        stage_in[0] = '{data: norm_data, c: norm_c, amt: norm_amt, ctrl: norm_ctrl};
        vld_in[0]   = in_valid;
        for (int k = 1; k < PIPE; k++) begin
            stage_in[k] = pay_q[k-1];
            vld_in[k]   = valid_q[k-1];
        end
    end

    // A stage can load unless it and every stage after it are full with the output stalled.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        can_load = '0;
        for (int k = PIPE - 1; k >= 0; k--) begin
            all_full    = all_full && valid_q[k];
            can_load[k] = !all_full || out_ready;
        end
    end

    always_comb begin
        payload_t p;
        p = '0;
        for (int k = 0; k < PIPE; k++) begin
            p = stage_in[k];
            for (int i = 0; i < LOG_W; i++) begin
                if (i >= k * LOG_W / PIPE && i < (k + 1) * LOG_W / PIPE && p.amt[i]) begin
                    p.data = layer(p.data, p.ctrl.op, p.ctrl.fill, 1 << i);
                end
            end
            if (k == PIPE - 1) begin
                if (p.ctrl.force_zero) begin
                    p.data = '0;
                end else if (p.ctrl.force_sign) begin
                    p.data = {W{p.ctrl.fill}};
                end
            end
            pay_nx[k] = p;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < PIPE; k++) begin
                pay_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (can_load[k]) begin
                    valid_q[k] <= vld_in[k];
                    if (vld_in[k]) begin
                        pay_q[k] <= pay_nx[k];
                    end
                end
            end
        end
    end

    assign in_ready  = can_load[0];
    assign out_valid = valid_q[PIPE-1];
    assign out_data  = pay_q[PIPE-1].data;
    assign out_c     = pay_q[PIPE-1].c;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: directed rule cases, a stalled stream, random traffic
// against a behavioural model, and an asynchronous reset with operands in flight.
module tb_shift_pipe;

    localparam int W     = 32;
    localparam int AMT_W = 8;
    localparam int PIPE  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic [1:0]       in_op = '0;
    logic             in_reg_form = 1'b0;
    logic             in_c = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_data;
    logic             out_c;

    shift_pipe #(
        .W     (W),
        .AMT_W (AMT_W),
        .PIPE  (PIPE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_amt      (in_amt),
        .in_op       (in_op),
        .in_reg_form (in_reg_form),
        .in_c        (in_c),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_c       (out_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    bit   lat_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Shifter semantics from the rule table, using wide arithmetic rather than mux layers.
    function automatic void ref_model(input logic [31:0] d, input logic [7:0] a,
                                      input logic [1:0] op, input logic rf, input logic c,
                                      output logic [31:0] r, output logic rc);
        int          n;
        logic [63:0] x;
        n  = rf ? int'(a) : int'(a[4:0]);
        r  = d;
        rc = c;
        if (!rf && n == 0) begin
            if (op == 2'd3) begin
                r  = {c, d[31:1]};
                rc = d[0];
                return;
            end
            if (op == 2'd0) return;
            n = 32;
        end
        if (n == 0) return;
        case (op)
            2'd0: begin
                x  = {32'b0, d} << n;
                r  = x[31:0];
                rc = (n <= 32) ? x[32] : 1'b0;
            end
            2'd1: begin
                x  = {d, 32'b0} >> n;
                r  = x[63:32];
                rc = (n <= 32) ? x[31] : 1'b0;
            end
            2'd2: begin
                if (n >= 32) begin
                    r  = {32{d[31]}};
                    rc = d[31];
                end else begin
                    r  = 32'($signed(d) >>> n);
                    rc = d[n-1];
                end
            end
            default: begin
                n  = n % 32;
                r  = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
                rc = r[31];
            end
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    exp_t         mon_e;
    bit           stall_prev = 1'b0;
    logic [W-1:0] held_d;
    logic         held_c;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!(q.size() == PIPE && !out_ready)));
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(held_d));
                chk("hold_c", 64'(out_c), 64'(held_c));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_out: got data %0h with nothing expected", out_data);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_data", 64'(out_data), 64'(mon_e.d));
                    chk("out_c", 64'(out_c), 64'(mon_e.c));
                    if (mon_e.lat) chk("latency", 64'(cyc + 1 - mon_e.cyc), 64'(PIPE));
                end
            end
            stall_prev = out_valid && !out_ready;
            held_d     = out_data;
            held_c     = out_c;
        end
    end

    // Entered and left at posedge+1; in_valid stays high so calls chain back-to-back.
    task automatic send(input logic [31:0] d, input logic [7:0] a, input logic [1:0] op,
                        input logic rf, input logic c, input bit use_exp,
                        input logic [31:0] xd, input logic xc);
        exp_t e;
        int   n;
        in_data     = d;
        in_amt      = a;
        in_op       = op;
        in_reg_form = rf;
        in_c        = c;
        in_valid    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout: in_ready got 0, expected 1 within 200 cycles");
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        if (use_exp) begin
            e.d = xd;
            e.c = xc;
        end else begin
            ref_model(d, a, op, rf, c, e.d, e.c);
        end
        e.cyc = cyc;
        e.lat = lat_mode;
        q.push_back(e);
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            n++;
            @(posedge clk);
        end
        #1;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    function automatic logic [7:0] rand_amt();
        case ($urandom_range(0, 6))
            0:       return 8'd0;
            1:       return 8'd1;
            2:       return 8'd31;
            3:       return 8'd32;
            4:       return 8'd33;
            5:       return 8'($urandom_range(0, 31));
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_c", 64'(out_c), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Rule-table cases with fixed expectations and an always-ready consumer.
        lat_mode = 1'b1;
        rdy_mode = 0;
        send(32'h1E1E1E1E, 8'd3,  2'd0, 1'b0, 1'b1, 1'b1, 32'hF0F0F0F0, 1'b0);
        send(32'h80000001, 8'd0,  2'd1, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1);
        send(32'h9E1E1E1E, 8'd0,  2'd2, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1);
        send(32'h00000003, 8'd0,  2'd3, 1'b0, 1'b1, 1'b1, 32'h80000001, 1'b1);
        send(32'h80000000, 8'd32, 2'd3, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b1);
        send(32'h00000001, 8'd32, 2'd0, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1);
        send(32'h00000001, 8'd33, 2'd0, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0);
        send(32'hA5A50F0F, 8'd0,  2'd1, 1'b1, 1'b1, 1'b1, 32'hA5A50F0F, 1'b1);
        send(32'hC3C30001, 8'd0,  2'd0, 1'b0, 1'b0, 1'b1, 32'hC3C30001, 1'b0);
        send(32'h12345678, 8'hE4, 2'd1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        send(32'h80000000, 8'd31, 2'd2, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        send(32'h0000F00F, 8'd36, 2'd3, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        drain();

        // Back-to-back stream against a consumer that accepts every other cycle.
        lat_mode = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            send($urandom, rand_amt(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        end
        drain();

        // Random traffic with random gaps and random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send($urandom, rand_amt(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Asynchronous reset with the pipe full and the consumer stalled.
        rdy_mode  = 3;
        out_ready = 1'b0;
        idle(1);
        send(32'hDEADBEEF, 8'd4, 2'd1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        send(32'h0BADF00D, 8'd7, 2'd0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        chk("async_rst_c", 64'(out_c), 64'd0);
        q.delete();
        rdy_mode  = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'h0000FFFF, 8'd8, 2'd0, 1'b1, 1'b0, 1'b1, 32'h00FFFF00, 1'b0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
